// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-to-word memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;

endpackage

// File: rtl/mem_ctrl.sv
// Bridges the core's byte-wide bus to a handshaked 16-bit SRAM port,
// with a one-word read buffer that serves the sibling byte without a memory cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter bit          BUF_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        cpu_out,
    input  logic              we,
    output logic [7:0]        cpu_in,
    output logic              ce,
    output logic [ADDR_W-2:0] sram_addr,
    output logic [15:0]       sram_dout,
    output logic [1:0]        sram_be,
    output logic              sram_we,
    output logic              sram_req,
    input  logic [15:0]       sram_din,
    input  logic              sram_ack
);

    localparam int unsigned WA_W = ADDR_W - 1;

    state_t          state;
    logic [15:0]     rd_buf;
    logic [WA_W-1:0] buf_tag;
    logic            buf_v;
    logic            hit;

    assign hit    = BUF_EN && buf_v && (buf_tag == address[ADDR_W-1:1]);
    assign cpu_in = address[0] ? rd_buf[15:8] : rd_buf[7:0];
    assign ce     = ((state == IDLE) && !we && hit) || (state == DONE);

    // The latched request lives in the sram_* registers for the whole REQ interval.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_buf    <= 16'h0000;
            buf_tag   <= '0;
            buf_v     <= 1'b0;
            sram_req  <= 1'b0;
            sram_we   <= 1'b0;
            sram_be   <= 2'b00;
            sram_addr <= '0;
            sram_dout <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (we || !hit) begin
                        sram_addr <= address[ADDR_W-1:1];
                        sram_be   <= address[0] ? BE_HI : BE_LO;
                        sram_dout <= {cpu_out, cpu_out};
                        sram_we   <= we;
                        sram_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (sram_ack) begin
                        sram_req <= 1'b0;
                        state    <= DONE;
                        if (!sram_we) begin
                            rd_buf  <= sram_din;
                            buf_tag <= sram_addr;
                            buf_v   <= 1'b1;
                        end else if (buf_v && (buf_tag == sram_addr)) begin
                            // Write-through keeps the buffered copy coherent byte by byte.
                            if (sram_be[0]) rd_buf[7:0]  <= sram_dout[7:0];
                            if (sram_be[1]) rd_buf[15:8] <= sram_dout[15:8];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized scoreboard bench for mem_ctrl: byte-level reference memory,
// a behavioural SRAM responder and an independent read-data monitor.
module tb_mem_ctrl;

    localparam int unsigned AW = 20;

    logic          clock;
    logic          reset;
    logic [AW-1:0] address;
    logic [7:0]    cpu_out;
    logic          we;
    logic [7:0]    cpu_in;
    logic          ce;
    logic [AW-2:0] sram_addr;
    logic [15:0]   sram_dout;
    logic [1:0]    sram_be;
    logic          sram_we;
    logic          sram_req;
    logic [15:0]   sram_din;
    logic          sram_ack;
    logic          ack_model;
    logic          spur_ack;

    assign sram_ack = ack_model | spur_ack;

    mem_ctrl #(.ADDR_W(AW), .BUF_EN(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .cpu_out   (cpu_out),
        .we        (we),
        .cpu_in    (cpu_in),
        .ce        (ce),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout),
        .sram_be   (sram_be),
        .sram_we   (sram_we),
        .sram_req  (sram_req),
        .sram_din  (sram_din),
        .sram_ack  (sram_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         word;
        logic [1:0] be;
        logic       we;
        logic [15:0] dout;
    } sreq_t;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sram_mem [int];
    logic [7:0]  ref_mem  [int];
    logic [7:0]  rdq [$];
    sreq_t       sq  [$];
    bit          bv;
    int          btag;
    bit          active;
    int          ack_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Create a word on first use in both the SRAM image and the byte reference.
    task automatic touch(input int word);
        logic [15:0] v;
        if (!sram_mem.exists(word)) begin
            v = 16'($urandom);
            sram_mem[word]      = v;
            ref_mem[2*word]     = v[7:0];
            ref_mem[2*word + 1] = v[15:8];
        end
    endtask

    task automatic preload(input int word, input logic [15:0] v);
        sram_mem[word]      = v;
        ref_mem[2*word]     = v[7:0];
        ref_mem[2*word + 1] = v[15:8];
    endtask

    // Predict hit/miss and memory traffic from the buffer rules, then present one access.
    task automatic issue(input logic [AW-1:0] a, input logic w, input logic [7:0] d,
                         input int lat, output bit hit);
        int    word;
        sreq_t e;
        word = int'(a[AW-1:1]);
        touch(word);
        hit = !w && bv && (btag == word);
        address = a;
        we      = w;
        cpu_out = d;
        ack_lat = lat;
        if (!w) rdq.push_back(ref_mem[int'(a)]);
        if (!hit) begin
            e.word = word;
            e.be   = a[0] ? 2'b10 : 2'b01;
            e.we   = w;
            e.dout = {d, d};
            sq.push_back(e);
        end
        if (w) ref_mem[int'(a)] = d;
        else if (!hit) begin
            bv   = 1'b1;
            btag = word;
        end
    endtask

    task automatic access(input logic [AW-1:0] a, input logic w, input logic [7:0] d, input int lat);
        bit hit;
        int stalls;
        int exp_st;
        issue(a, w, d, lat, hit);
        active = !w;
        stalls = 0;
        exp_st = hit ? 0 : lat + 1;
        forever begin
            @(negedge clock);
            if (ce === 1'b1) break;
            stalls++;
            if (stalls > 200) break;
        end
        chk("ce_stall_cycles", 32'(stalls), 32'(exp_st));
        @(posedge clock);
        #1;
        active = 1'b0;
    endtask

    // Read-data monitor: every read completion consumes one expected byte.
    always @(negedge clock) begin
        logic [7:0] e;
        if (!reset && active && ce === 1'b1 && !we) begin
            if (rdq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else begin
                e = rdq.pop_front();
                chk("cpu_in", 32'(cpu_in), 32'(e));
            end
        end
    end

    // SRAM responder: acks after ack_lat request cycles, checks the request fields.
    int    m_cnt;
    int    m_lat;
    bit    m_busy;
    sreq_t m_exp;
    always @(negedge clock or posedge reset) begin
        if (reset) begin
            ack_model = 1'b0;
            m_busy    = 1'b0;
        end else begin
            ack_model = 1'b0;
            sram_din  = 16'($urandom);
            if (sram_req) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_lat  = ack_lat;
                    if (sq.size() == 0) begin
                        chk("sram_unexpected_req", 32'd1, 32'd0);
                        m_exp.word = int'(sram_addr);
                        m_exp.be   = sram_be;
                        m_exp.we   = sram_we;
                        m_exp.dout = sram_dout;
                    end else begin
                        m_exp = sq.pop_front();
                        chk("sram_addr", 32'(sram_addr), 32'(m_exp.word));
                        chk("sram_be",   32'(sram_be),   32'(m_exp.be));
                        chk("sram_we",   32'(sram_we),   32'(m_exp.we));
                        chk("sram_dout", 32'(sram_dout), 32'(m_exp.dout));
                    end
                end
                m_cnt++;
                if (m_cnt == m_lat) begin
                    chk("sram_addr_stable", 32'(sram_addr), 32'(m_exp.word));
                    ack_model = 1'b1;
                    m_busy    = 1'b0;
                    if (sram_we) begin
                        if (sram_be[0]) sram_mem[int'(sram_addr)][7:0]  = sram_dout[7:0];
                        if (sram_be[1]) sram_mem[int'(sram_addr)][15:8] = sram_dout[15:8];
                    end else begin
                        sram_din = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 16'h0000;
                    end
                end
            end
        end
    end

    initial begin
        bit          h;
        int          prev_word;
        int          r;
        logic [AW-1:0] a;
        reset    = 1'b1;
        address  = '0;
        we       = 1'b0;
        cpu_out  = 8'h00;
        spur_ack = 1'b0;
        active   = 1'b0;
        bv       = 1'b0;
        btag     = 0;
        ack_lat  = 1;
        sram_din = 16'h0000;
        preload(0, 16'h5512);
        preload(20'h7FFF8, 16'h00EA);

        repeat (2) @(posedge clock);
        #1;
        chk("rst_sram_req",  32'(sram_req),  32'd0);
        chk("rst_sram_we",   32'(sram_we),   32'd0);
        chk("rst_sram_be",   32'(sram_be),   32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_dout", 32'(sram_dout), 32'd0);
        chk("rst_ce",        32'(ce),        32'd0);
        chk("rst_cpu_in",    32'(cpu_in),    32'd0);
        reset = 1'b0;

        access(20'h00000, 1'b0, 8'h33, 1);
        access(20'h00001, 1'b0, 8'h44, 1);
        access(20'h00001, 1'b1, 8'hAB, 2);
        access(20'h00001, 1'b0, 8'h00, 1);

        // Spurious ack while parked on a hit must not start anything.
        spur_ack = 1'b1;
        @(posedge clock);
        #1;
        spur_ack = 1'b0;
        @(negedge clock);
        chk("spur_sram_req", 32'(sram_req), 32'd0);
        chk("spur_ce",       32'(ce),       32'd1);
        @(posedge clock);
        #1;

        access(20'hFFFF0, 1'b0, 8'h5A, 5);
        access(20'hFFFFF, 1'b0, 8'h11, 1);
        access(20'h00000, 1'b0, 8'h22, 1);

        // Abandon a request with reset two cycles into REQ.
        issue(20'h00100, 1'b0, 8'h66, 10, h);
        void'(rdq.pop_back());
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("rstreq_sram_req", 32'(sram_req), 32'd0);
        chk("rstreq_ce",       32'(ce),       32'd0);
        chk("rstreq_cpu_in",   32'(cpu_in),   32'd0);
        bv = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        access(20'h00001, 1'b0, 8'h00, 2);

        prev_word = 1;
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      a = {AW'(prev_word)} << 1;
            else if (r < 6) a = AW'($urandom_range(0, 7));
            else if (r < 7) a = 20'hFFFFE;
            else if (r < 8) a = 20'hFFFF0;
            else            a = AW'($urandom);
            a[0] = 1'($urandom_range(0, 1));
            prev_word = int'(a[AW-1:1]);
            access(a, ($urandom_range(0, 9) < 3), 8'($urandom), int'($urandom_range(1, 4)));
        end

        access(20'h00002, 1'b0, 8'h00, 1);
        repeat (4) @(posedge clock);
        #1;
        chk("rdq_drained",  32'(rdq.size()), 32'd0);
        chk("sram_drained", 32'(sq.size()),  32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
